// File: rtl/mux16_rr_arbiter_if.sv
// Request/select/handshake bundle between the round-robin arbiter and the
// requesters plus downstream consumer of the 16-input data mux.
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic        out_valid;
  logic [15:0] grant;
  logic [15:0] req_ack;
  logic        busy;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output out_valid,
    output grant,
    output req_ack,
    output busy
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  out_valid,
    input  grant,
    input  req_ack,
    input  busy
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the 4-bit select of a 16-input data mux, with a
// valid/ready handshake toward the consumer and bounded burst continuation.
module mux16_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux16_rr_arbiter_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         sel_r, sel_s;
  logic               valid_r, valid_s;
  logic [15:0]        grant_r, grant_s;
  logic               busy_r, busy_s;
  logic [3:0]         ptr_r, ptr_s;
  logic [BURST_W-1:0] cnt_r, cnt_s;
  logic [15:0]        rot_s;
  logic [3:0]         off_s;
  logic [3:0]         winner_s;
  logic               accept_s;

  assign accept_s = valid_r & bus.out_ready;

  // Rotate requests so bit 0 is the current priority pointer, then take the lowest set bit.
  always_comb begin
    rot_s = 16'({bus.req, bus.req} >> ptr_r);
    off_s = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = 4'(i);
      end else begin
        off_s = off_s;
      end
    end
    winner_s = ptr_r + off_s;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    valid_s = valid_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          state_s = ST_GRANT;
          sel_s   = winner_s;
          valid_s = 1'b1;
          cnt_s   = {BURST_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (accept_s) begin
          // Continue only while the same requester still has a word and the burst budget remains.
          if (bus.req[sel_r] && (cnt_r < LAST_BEAT)) begin
            cnt_s = cnt_r + BURST_W'(1);
          end else begin
            state_s = ST_IDLE;
            valid_s = 1'b0;
            ptr_s   = sel_r + 4'd1;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
    grant_s = valid_s ? onehot16(sel_s) : 16'h0000;
    busy_s  = (state_s == ST_GRANT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= 4'd0;
      valid_r <= 1'b0;
      grant_r <= 16'h0000;
      busy_r  <= 1'b0;
      ptr_r   <= 4'd0;
      cnt_r   <= {BURST_W{1'b0}};
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      valid_r <= valid_s;
      grant_r <= grant_s;
      busy_r  <= busy_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
    end
  end

  // The acknowledge must coincide with the accepted beat, so it is decoded from the live handshake.
  assign bus.req_ack   = accept_s ? onehot16(sel_r) : 16'h0000;
  assign bus.sel       = sel_r;
  assign bus.out_valid = valid_r;
  assign bus.grant     = grant_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: two instances (MAX_BURST=1 and 4) share stimulus
// and are checked against directed expectations and a behavioural model.
module tb_mux16_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  int          n_checks;
  int          n_fail;

  mux16_rr_arbiter_if bus1 ();
  mux16_rr_arbiter_if bus4 ();

  assign bus1.req       = req;
  assign bus1.out_ready = out_ready;
  assign bus4.req       = req;
  assign bus4.out_ready = out_ready;

  mux16_rr_arbiter #(.MAX_BURST(1), .BURST_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux16_rr_arbiter #(.MAX_BURST(4), .BURST_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // index 0 -> MAX_BURST=1 instance, index 1 -> MAX_BURST=4 instance
  logic [3:0]  o_sel[2];
  logic        o_valid[2];
  logic [15:0] o_grant[2];
  logic [15:0] o_ack[2];
  logic        o_busy[2];

  assign o_sel[0]   = bus1.sel;       assign o_sel[1]   = bus4.sel;
  assign o_valid[0] = bus1.out_valid; assign o_valid[1] = bus4.out_valid;
  assign o_grant[0] = bus1.grant;     assign o_grant[1] = bus4.grant;
  assign o_ack[0]   = bus1.req_ack;   assign o_ack[1]   = bus4.req_ack;
  assign o_busy[0]  = bus1.busy;      assign o_busy[1]  = bus4.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic       m_busy[2];
  logic [3:0] m_sel[2];
  int         m_ptr[2];
  int         m_cnt[2];

  function automatic int burst_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int first_req(input logic [15:0] r, input int p);
    for (int i = 0; i < 16; i++) begin
      if (r[(p + i) % 16]) return (p + i) % 16;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0; m_sel[k] <= 4'd0; m_ptr[k] <= 0; m_cnt[k] <= 0;
      end else if (!m_busy[k]) begin
        if (req != 16'h0000) begin
          m_sel[k]  <= 4'(first_req(req, m_ptr[k]));
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= 0;
        end
      end else if (out_ready) begin
        if (req[m_sel[k]] && (m_cnt[k] + 1 < burst_of(k))) begin
          m_cnt[k] <= m_cnt[k] + 1;
        end else begin
          m_busy[k] <= 1'b0;
          m_ptr[k]  <= (int'(m_sel[k]) + 1) % 16;
        end
      end
    end
  end

  // ---------------- timing helpers ----------------
  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    go(); rst = 1'b1; req = 16'h0000; out_ready = 1'b0; mid();
    go(); rst = 1'b0; mid();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    go(); rst = 1'b1; req = 16'hFFFF; out_ready = 1'b0; mid();
    go(); mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_sel[k] !== 4'd0) begin n_fail++; $display("FAIL reset_sel[%0d]: got %0h want 0", k, o_sel[k]); end
      n_checks++; if (o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, o_valid[k]); end
      n_checks++; if (o_grant[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_grant[%0d]: got %h want 0000", k, o_grant[k]); end
      n_checks++; if (o_ack[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_ack[%0d]: got %h want 0000", k, o_ack[k]); end
      n_checks++; if (o_busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, o_busy[k]); end
    end
    go(); rst = 1'b0; mid();
    go(); mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_valid[k] !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid[%0d]: got %b want 1", k, o_valid[k]); end
      n_checks++; if (o_sel[k] !== 4'd0) begin n_fail++; $display("FAIL post_reset_sel[%0d]: got %0h want 0", k, o_sel[k]); end
      n_checks++; if (o_grant[k] !== 16'h0001) begin n_fail++; $display("FAIL post_reset_grant[%0d]: got %h want 0001", k, o_grant[k]); end
    end
  endtask

  task automatic test_rotation();
    logic        ev;
    logic [3:0]  es;
    logic [15:0] ea;
    reset_dut();
    go(); req = 16'h8001; out_ready = 1'b1; mid();
    for (int i = 0; i < 8; i++) begin
      go(); mid();
      ev = (i % 2 == 0);
      es = (i % 4 < 2) ? 4'd0 : 4'd15;
      ea = ev ? ((es == 4'd0) ? 16'h0001 : 16'h8000) : 16'h0000;
      n_checks++; if (o_valid[0] !== ev) begin n_fail++; $display("FAIL rot_valid cyc%0d: got %b want %b", i, o_valid[0], ev); end
      n_checks++; if (o_sel[0] !== es) begin n_fail++; $display("FAIL rot_sel cyc%0d: got %0d want %0d", i, o_sel[0], es); end
      n_checks++; if (o_ack[0] !== ea) begin n_fail++; $display("FAIL rot_ack cyc%0d: got %h want %h", i, o_ack[0], ea); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] q[$];
    logic [4:0] got;
    logic [4:0] want[3];
    want[0] = 5'd14; want[1] = 5'd0; want[2] = 5'd14;
    reset_dut();
    go(); req = 16'h4000; out_ready = 1'b1; mid();
    for (int i = 0; i < 6; i++) begin
      go();
      if (i == 0) req = 16'h4001;
      mid();
      if (o_valid[0] === 1'b1) q.push_back(o_sel[0]);
    end
    n_checks++; if (q.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d grants want 3", q.size()); end
    for (int j = 0; j < 3; j++) begin
      got = (j < q.size()) ? {1'b0, q[j]} : 5'h1F;
      n_checks++; if (got !== want[j]) begin n_fail++; $display("FAIL wrap_sel[%0d]: got %0d want %0d", j, got, want[j]); end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    go(); req = 16'h0020; out_ready = 1'b0; mid();
    go(); mid();
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (o_sel[k] !== 4'd5) begin n_fail++; $display("FAIL bp_sel[%0d] cyc%0d: got %0d want 5", k, i, o_sel[k]); end
        n_checks++; if (o_valid[k] !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] cyc%0d: got %b want 1", k, i, o_valid[k]); end
        n_checks++; if (o_ack[k] !== 16'h0000) begin n_fail++; $display("FAIL bp_ack[%0d] cyc%0d: got %h want 0000", k, i, o_ack[k]); end
      end
      go(); mid();
    end
    go(); out_ready = 1'b1; req = 16'h0000; mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ack[k] !== 16'h0020) begin n_fail++; $display("FAIL bp_release_ack[%0d]: got %h want 0020", k, o_ack[k]); end
    end
    go(); mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ack[k] !== 16'h0000) begin n_fail++; $display("FAIL bp_ack_once[%0d]: got %h want 0000", k, o_ack[k]); end
      n_checks++; if (o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL bp_bubble_valid[%0d]: got %b want 0", k, o_valid[k]); end
    end
  endtask

  task automatic test_burst();
    logic        ev;
    logic [3:0]  es;
    logic [15:0] ea;
    reset_dut();
    go(); req = 16'h0018; out_ready = 1'b1; mid();
    for (int i = 0; i < 6; i++) begin
      go(); mid();
      ev = (i != 4);
      es = (i < 5) ? 4'd3 : 4'd4;
      ea = (i < 4) ? 16'h0008 : ((i == 5) ? 16'h0010 : 16'h0000);
      n_checks++; if (o_valid[1] !== ev) begin n_fail++; $display("FAIL burst_valid cyc%0d: got %b want %b", i, o_valid[1], ev); end
      n_checks++; if (o_sel[1] !== es) begin n_fail++; $display("FAIL burst_sel cyc%0d: got %0d want %0d", i, o_sel[1], es); end
      n_checks++; if (o_ack[1] !== ea) begin n_fail++; $display("FAIL burst_ack cyc%0d: got %h want %h", i, o_ack[1], ea); end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    go(); req = 16'h0200; out_ready = 1'b1; mid();
    go(); req = 16'h0000; mid();
    go(); req = 16'h0008; mid();
    go(); mid();
    go(); mid();
    go(); rst = 1'b1; mid();
    n_checks++; if (o_ack[1] !== 16'h0008) begin n_fail++; $display("FAIL midrst_beat2_ack: got %h want 0008", o_ack[1]); end
    go(); rst = 1'b0; req = 16'h0408; mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_sel[k] !== 4'd0) begin n_fail++; $display("FAIL midrst_sel[%0d]: got %0h want 0", k, o_sel[k]); end
      n_checks++; if (o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid[%0d]: got %b want 0", k, o_valid[k]); end
      n_checks++; if (o_grant[k] !== 16'h0000) begin n_fail++; $display("FAIL midrst_grant[%0d]: got %h want 0000", k, o_grant[k]); end
      n_checks++; if (o_ack[k] !== 16'h0000) begin n_fail++; $display("FAIL midrst_ack[%0d]: got %h want 0000", k, o_ack[k]); end
      n_checks++; if (o_busy[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy[%0d]: got %b want 0", k, o_busy[k]); end
    end
    go(); mid();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_sel[k] !== 4'd3) begin n_fail++; $display("FAIL midrst_restart_sel[%0d]: got %0d want 3", k, o_sel[k]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] eg;
    logic [15:0] ea;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      go();
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       req = 16'($urandom);
        1:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: req = 16'h0001 << $urandom_range(0, 15);
      endcase
      // requesters never withdraw a word that is still pending
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] && !out_ready) req[m_sel[k]] = 1'b1;
      end
      rst = ($urandom_range(0, 199) == 0);
      mid();
      for (int k = 0; k < 2; k++) begin
        eg = m_busy[k] ? (16'h0001 << m_sel[k]) : 16'h0000;
        ea = (m_busy[k] && out_ready) ? eg : 16'h0000;
        n_checks++; if (o_valid[k] !== m_busy[k]) begin n_fail++; $display("FAIL rnd_valid[%0d] t=%0t: got %b want %b", k, $time, o_valid[k], m_busy[k]); end
        n_checks++; if (o_busy[k] !== m_busy[k]) begin n_fail++; $display("FAIL rnd_busy[%0d] t=%0t: got %b want %b", k, $time, o_busy[k], m_busy[k]); end
        n_checks++; if (o_sel[k] !== m_sel[k]) begin n_fail++; $display("FAIL rnd_sel[%0d] t=%0t: got %0d want %0d", k, $time, o_sel[k], m_sel[k]); end
        n_checks++; if (o_grant[k] !== eg) begin n_fail++; $display("FAIL rnd_grant[%0d] t=%0t: got %h want %h", k, $time, o_grant[k], eg); end
        n_checks++; if (o_ack[k] !== ea) begin n_fail++; $display("FAIL rnd_ack[%0d] t=%0t: got %h want %h", k, $time, o_ack[k], ea); end
        n_checks++; if ((o_ack[k] & ~o_grant[k]) !== 16'h0000) begin n_fail++; $display("FAIL rnd_ack_subset[%0d] t=%0t: ack %h grant %h", k, $time, o_ack[k], o_grant[k]); end
      end
    end
    go(); rst = 1'b0; mid();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 16'h0000;
    out_ready = 1'b0;
    mid();
    test_reset();
    test_rotation();
    test_wrap();
    test_backpressure();
    test_burst();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
